capture_seq_ctrl: RTL and testbench
===================================

Name: capture_seq_ctrl

Overview:
- Sequences one ADC capture into the on-chip capture memory and arbitrates the memory read port afterwards.
- Owns the write side of capture memory.
  - Start/again pulses come from the regfile.
  - Optionally discards the first N valid samples, then fills DEPTH samples.
- Read-port ownership goes to one of two masters:
  - the packet controller (packet readout), or
  - the MDIO memory-read path.
- Sits between the regfile (capture_start/again/mode) and the capture memory, alongside the packet controller.

Parameters:
- ADDR_W, 14, capture memory address width.
- DEPTH, 12288, samples per capture; 2 <= DEPTH <= 2^ADDR_W.
- SKIP_W, 8, width of the sample-skip count.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_capture_start  in  1  single-cycle start pulse.
- cfg_capture_again  in  1  single-cycle recapture pulse.
- cfg_capture_mode  in  1  0 = packet readout, 1 = MDIO readout.
- cfg_skip_cnt  in  SKIP_W  number of valid samples discarded before the fill.
- adc_valid  in  1  ADC sample strobe.
- mem_wr_en  out  1  capture memory write enable.
- mem_wr_addr  out  ADDR_W  capture memory write address.
- pkt_rd_grant  out  1  packet controller owns the read port.
- pkt_rd_addr  in  ADDR_W  packet controller read address.
- pkt_rd_done  in  1  packet controller finished its readout (pulse).
- mdio_rd_addr  in  ADDR_W  MDIO read address.
- mem_rd_addr  out  ADDR_W  muxed capture memory read address.
- cap_busy  out  1  high in SKIP or FILL.
- cap_done  out  1  memory holds a complete capture.
- cap_state  out  3  current state encoding, for debug.
- cap_frame_cnt  out  16  count of completed captures (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; internal skip counter 0.
- States and encodings: IDLE=0, SKIP=1, FILL=2, FULL=3, READ=4.
- Arm event = start OR again (same cycle). Arming:
  - clears cap_done and mem_wr_addr;
  - loads the skip counter with cfg_skip_cnt;
  - moves the next state to SKIP, or to FILL if cfg_skip_cnt==0.
- IDLE: start or again arms. adc_valid is ignored.
- SKIP: each adc_valid decrements the skip counter. When adc_valid arrives with count==1, move to FILL next cycle. That sample is discarded.
- FILL:
  - mem_wr_en = adc_valid (combinational, this cycle) and mem_wr_addr is the current registered address.
  - After each write, the address increments.
  - The write at DEPTH-1 wraps the address to 0 and moves to FULL; cap_done=1 from the next cycle.
- FULL:
  - cap_done=1.
  - If cfg_capture_mode==0, go to READ next cycle.
  - If mode==1, stay in FULL indefinitely.
- READ:
  - pkt_rd_grant=1.
  - pkt_rd_done moves back to FULL.
  - A mode change does not preempt READ; readout completes first.
- Read mux: mem_rd_addr = pkt_rd_addr when state==READ, otherwise mdio_rd_addr. Combinational, zero latency.
- Re-arming mid-operation:
  - again in SKIP, FILL, FULL or READ re-arms immediately; any partial fill is abandoned.
  - In READ, pkt_rd_grant drops the next cycle.
  - start in SKIP or FILL is ignored.
  - start in FULL or READ re-arms like again.
- Simultaneous events:
  - again and pkt_rd_done in the same cycle: again wins.
  - The final fill write and again in the same cycle: again wins, the FULL transition is lost, and cap_frame_cnt does not increment.
- pkt_rd_done outside READ is ignored.
- Asynchronous reset mid-capture returns to IDLE with all outputs 0. Memory contents are not touched.

Optional Feature:
- Macro CAPSEQ_FRAME_CNT_EN.
- Defined: cap_frame_cnt increments by 1 on each FILL->FULL transition, wraps at 0xFFFF->0, and is cleared only by reset.
- Undefined: cap_frame_cnt is tied to 0 and no counter flops are generated.

Test Plan:
- DEPTH=16, cfg_skip_cnt=0, start pulse, adc_valid continuous:
  - mem_wr_en high 16 cycles, addresses 0..15;
  - cap_done=1 one cycle after the address-15 write;
  - mem_wr_addr returns to 0.
- DEPTH=16, cfg_skip_cnt=3, adc_valid every other cycle:
  - first 3 valids are not written;
  - 4th valid is written at address 0;
  - cap_busy is high from the cycle after start until FULL.
- mode=0 after FULL:
  - pkt_rd_grant=1 and mem_rd_addr follows pkt_rd_addr=0x005;
  - pkt_rd_done gives grant 0 the next cycle, state=3, and mem_rd_addr follows mdio_rd_addr=0x004.
- mode=1: stays in FULL indefinitely with no grant. Then set mode=0: READ next cycle.
- Start pulse during FILL at address 7: ignored. Again pulse at address 9:
  - state goes to SKIP/FILL and mem_wr_addr=0;
  - with the macro defined, cap_frame_cnt is unchanged until the new fill completes, then becomes +1.
- rstn low while in FILL at address 5: all outputs 0 and state IDLE immediately. After release, adc_valid produces no writes until start.

Source files
------------

// File: rtl/capture_seq_ctrl.sv
// capture_seq_ctrl: sequences one ADC capture into capture memory (optional
// sample skip, then DEPTH writes) and afterwards hands the memory read port
// to either the packet controller or the MDIO read path.
// Optional feature macro: CAPSEQ_FRAME_CNT_EN -- when defined, cap_frame_cnt
// counts completed captures; when undefined it is tied to zero.
//
// Handshake note: all control inputs are single-cycle pulses or levels sampled
// on the rising clock edge; there is no valid/ready back-pressure. Writes are
// fire-and-forget: mem_wr_en is asserted in the same cycle as adc_valid while
// filling, and the memory must accept the write that cycle.
module capture_seq_ctrl #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 12288,
   parameter int SKIP_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cfg_capture_start,
   input  logic              cfg_capture_again,
   input  logic              cfg_capture_mode,
   input  logic [SKIP_W-1:0] cfg_skip_cnt,
   input  logic              adc_valid,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic              pkt_rd_grant,
   input  logic [ADDR_W-1:0] pkt_rd_addr,
   input  logic              pkt_rd_done,
   input  logic [ADDR_W-1:0] mdio_rd_addr,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              cap_busy,
   output logic              cap_done,
   output logic [2:0]        cap_state,
   output logic [15:0]       cap_frame_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SKIP = 3'd1,
      ST_FILL = 3'd2,
      ST_FULL = 3'd3,
      ST_READ = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              grant_q, grant_d;
   logic              arm;
   logic              fill_wr;
   logic              fill_last;
   logic              frame_inc;

   // Arm decode: again always re-arms; start only where no capture is in flight.
   always_comb begin
      arm       = cfg_capture_again |
                  (cfg_capture_start & ((state_q == ST_IDLE) |
                                        (state_q == ST_FULL) |
                                        (state_q == ST_READ)));
      fill_wr   = (state_q == ST_FILL) & adc_valid;
      fill_last = fill_wr & (addr_q == LAST_ADDR);
      // A re-arm on the final write cancels the FULL transition.
      frame_inc = fill_last & ~arm;
   end

   // Next-state and datapath: re-arming takes priority over every state action.
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      addr_d  = addr_q;
      done_d  = done_q;
      if (arm) begin
         done_d  = 1'b0;
         addr_d  = '0;
         skip_d  = cfg_skip_cnt;
         state_d = (cfg_skip_cnt == '0) ? ST_FILL : ST_SKIP;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SKIP: begin
               if (adc_valid) begin
                  skip_d = skip_q - SKIP_W'(1);
                  // The sample that brings the count to zero is still discarded.
                  if (skip_q <= SKIP_W'(1)) state_d = ST_FILL;
               end
            end
            ST_FILL: begin
               if (fill_wr) begin
                  if (fill_last) begin
                     addr_d  = '0;
                     state_d = ST_FULL;
                     done_d  = 1'b1;
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
            ST_FULL: if (!cfg_capture_mode) state_d = ST_READ;
            ST_READ: if (pkt_rd_done) state_d = ST_FULL;
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d  = (state_d == ST_SKIP) | (state_d == ST_FILL);
      grant_d = (state_d == ST_READ);
   end

   // State and registered status flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         skip_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         grant_q <= grant_d;
      end
   end

   assign mem_wr_en    = fill_wr;
   assign mem_wr_addr  = addr_q;
   assign pkt_rd_grant = grant_q;
   assign mem_rd_addr  = grant_q ? pkt_rd_addr : mdio_rd_addr;
   assign cap_busy     = busy_q;
   assign cap_done     = done_q;
   assign cap_state    = state_q;

`ifdef CAPSEQ_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Completed-capture counter; wraps naturally at 16 bits.
   always_comb begin
      frame_cnt_d = frame_cnt_q + (frame_inc ? 16'd1 : 16'd0);
   end

   // Counter flop, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) frame_cnt_q <= 16'd0;
      else       frame_cnt_q <= frame_cnt_d;
   end

   assign cap_frame_cnt = frame_cnt_q;
`else
   logic unused_frame_inc;
   assign unused_frame_inc = frame_inc;
   assign cap_frame_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Testbench for capture_seq_ctrl with DEPTH=16: directed sequences, a
// behavioural capture model compared every cycle, and literal expectations.
module tb_capture_seq_ctrl;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 16;
   localparam int SKIP_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic              start, again, mode, valid, pkt_done;
   logic [SKIP_W-1:0] skip_cnt;
   logic [ADDR_W-1:0] pkt_addr, mdio_addr;
   logic              mem_wr_en, pkt_rd_grant, cap_busy, cap_done;
   logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
   logic [2:0]        cap_state;
   logic [15:0]       cap_frame_cnt;

   capture_seq_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SKIP_W(SKIP_W)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_capture_start(start), .cfg_capture_again(again),
      .cfg_capture_mode(mode), .cfg_skip_cnt(skip_cnt),
      .adc_valid(valid),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .pkt_rd_grant(pkt_rd_grant), .pkt_rd_addr(pkt_addr), .pkt_rd_done(pkt_done),
      .mdio_rd_addr(mdio_addr), .mem_rd_addr(mem_rd_addr),
      .cap_busy(cap_busy), .cap_done(cap_done), .cap_state(cap_state),
      .cap_frame_cnt(cap_frame_cnt)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [ADDR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] wr_log[$];
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_log(input string name);
      chk({name, "_count"}, wr_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
         chk({name, "_addr"}, wr_log[i], exp_q[i]);
   endtask

   task automatic exp_seq(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'(i));
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 discarding, 2 filling, 3 holding full, 4 packet readout
   int          m_phase   = 0;
   int          m_discard = 0;
   int          m_count   = 0;
   bit          m_full    = 1'b0;
   logic [15:0] m_frames  = 16'd0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_phase = 0; m_discard = 0; m_count = 0; m_full = 1'b0; m_frames = 16'd0;
      end else if (again || (start && (m_phase == 0 || m_phase >= 3))) begin
         m_full    = 1'b0;
         m_count   = 0;
         m_discard = int'(skip_cnt);
         m_phase   = (m_discard == 0) ? 2 : 1;
      end else if (m_phase == 1 && valid) begin
         m_discard = m_discard - 1;
         if (m_discard == 0) m_phase = 2;
      end else if (m_phase == 2 && valid) begin
         m_count = m_count + 1;
         if (m_count == DEPTH) begin
            m_count  = 0;
            m_phase  = 3;
            m_full   = 1'b1;
            m_frames = m_frames + 16'd1;
         end
      end else if (m_phase == 3 && !mode) begin
         m_phase = 4;
      end else if (m_phase == 4 && pkt_done) begin
         m_phase = 3;
      end
   end

   // Compare process: mid-low-phase, after inputs for the next edge are set.
   always @(negedge clk) begin
      #2;
      if (chk_on) begin
         chk("cmp_state", cap_state, m_phase);
         chk("cmp_wr_en", mem_wr_en, (m_phase == 2) && valid);
         chk("cmp_wr_addr", mem_wr_addr, m_count);
         chk("cmp_busy", cap_busy, (m_phase == 1) || (m_phase == 2));
         chk("cmp_done", cap_done, m_full);
         chk("cmp_grant", pkt_rd_grant, m_phase == 4);
         chk("cmp_rd_addr", mem_rd_addr, (m_phase == 4) ? pkt_addr : mdio_addr);
`ifdef CAPSEQ_FRAME_CNT_EN
         chk("cmp_frames", cap_frame_cnt, m_frames);
`else
         chk("cmp_frames", cap_frame_cnt, 0);
`endif
         if (mem_wr_en === 1'b1) wr_log.push_back(mem_wr_addr);
      end
   end

   // ---------------- driver ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [15:0] frames_exp(input int n);
`ifdef CAPSEQ_FRAME_CNT_EN
      return 16'(n);
`else
      return 16'd0 + 16'(n - n);
`endif
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; start = 0; again = 0; mode = 1; skip_cnt = 0; valid = 0;
      pkt_addr = 0; pkt_done = 0; mdio_addr = 0;
      chk_on = 1'b1;
      repeat (3) cyc();
      #1;
      chk("rst_state", cap_state, 0);
      chk("rst_done", cap_done, 0);
      chk("rst_wr_addr", mem_wr_addr, 0);
      chk("rst_busy", cap_busy, 0);
      chk("rst_grant", pkt_rd_grant, 0);
      chk("rst_frames", cap_frame_cnt, 0);
      cyc(); rstn = 1'b1; valid = 1;
      repeat (3) cyc();
      #1;
      chk("idle_state", cap_state, 0);
      chk("idle_no_wr", wr_log.size(), 0);

      // T1: no skip, continuous valid
      cyc(); wr_log.delete(); skip_cnt = 0; start = 1; valid = 1;
      cyc(); start = 0;
      #1;
      chk("t1_fill", cap_state, 2);
      chk("t1_busy", cap_busy, 1);
      chk("t1_addr0", mem_wr_addr, 0);
      repeat (15) cyc();
      #1;
      chk("t1_addr15", mem_wr_addr, 15);
      chk("t1_wr15", mem_wr_en, 1);
      chk("t1_notdone", cap_done, 0);
      cyc(); valid = 0;
      #1;
      chk("t1_full", cap_state, 3);
      chk("t1_done", cap_done, 1);
      chk("t1_addr_wrap", mem_wr_addr, 0);
      chk("t1_frames", cap_frame_cnt, frames_exp(1));
      exp_seq(16); check_log("t1_log");

      // T3: mode 1 holds FULL, stray pkt_rd_done ignored, then packet readout
      cyc(); pkt_done = 1;
      cyc(); pkt_done = 0;
      repeat (4) cyc();
      #1;
      chk("m1_state", cap_state, 3);
      chk("m1_grant", pkt_rd_grant, 0);
      cyc(); mode = 0; pkt_addr = 14'h005; mdio_addr = 14'h004;
      #1;
      chk("m1_rd_mdio", mem_rd_addr, 14'h004);
      cyc();
      #1;
      chk("rd_state", cap_state, 4);
      chk("rd_grant", pkt_rd_grant, 1);
      chk("rd_pkt_addr", mem_rd_addr, 14'h005);
      cyc(); mode = 1;
      cyc();
      #1;
      chk("rd_no_preempt", cap_state, 4);
      pkt_done = 1;
      cyc(); pkt_done = 0;
      #1;
      chk("rd_done_grant", pkt_rd_grant, 0);
      chk("rd_done_state", cap_state, 3);
      chk("rd_done_mdio", mem_rd_addr, 14'h004);

      // T2: skip 3, valid every other cycle; start re-arms from FULL
      cyc(); wr_log.delete(); skip_cnt = 3; start = 1; valid = 0;
      cyc(); start = 0;
      #1;
      chk("t2_skip", cap_state, 1);
      chk("t2_busy", cap_busy, 1);
      chk("t2_notdone", cap_done, 0);
      for (int i = 0; i < 40; i++) begin
         if (i == 5) begin
            #1;
            chk("t2_fill", cap_state, 2);
            chk("t2_addr0", mem_wr_addr, 0);
            chk("t2_no_wr", wr_log.size(), 0);
         end
         valid = (i % 2 == 0);
         cyc();
      end
      valid = 0;
      #1;
      chk("t2_full", cap_state, 3);
      chk("t2_done", cap_done, 1);
      chk("t2_frames", cap_frame_cnt, frames_exp(2));
      exp_seq(16); check_log("t2_log");

      // T4: start ignored mid-fill, again at address 9
      cyc(); skip_cnt = 0; again = 1; valid = 1;
      cyc(); again = 0;
      repeat (7) cyc();
      #1;
      chk("t4_addr7", mem_wr_addr, 7);
      start = 1;
      cyc(); start = 0;
      #1;
      chk("t4_start_ign", cap_state, 2);
      chk("t4_addr8", mem_wr_addr, 8);
      cyc();
      #1;
      chk("t4_addr9", mem_wr_addr, 9);
      again = 1; skip_cnt = 2;
      cyc(); again = 0;
      #1;
      chk("t4_rearm", cap_state, 1);
      chk("t4_addr_clr", mem_wr_addr, 0);
      chk("t4_frames_hold", cap_frame_cnt, frames_exp(2));
      repeat (18) cyc();
      #1;
      chk("t4_full", cap_state, 3);
      chk("t4_frames_inc", cap_frame_cnt, frames_exp(3));

      // T5: again on the final fill write wins
      cyc(); skip_cnt = 0; again = 1;
      cyc(); again = 0;
      repeat (15) cyc();
      #1;
      chk("t5_addr15", mem_wr_addr, 15);
      again = 1;
      cyc(); again = 0;
      #1;
      chk("t5_state", cap_state, 2);
      chk("t5_addr", mem_wr_addr, 0);
      chk("t5_notdone", cap_done, 0);
      chk("t5_frames", cap_frame_cnt, frames_exp(3));
      repeat (16) cyc();
      #1;
      chk("t5_full", cap_state, 3);
      chk("t5_frames_inc", cap_frame_cnt, frames_exp(4));

      // T7: again and pkt_rd_done together in READ; again wins
      mode = 0;
      cyc();
      #1;
      chk("t7_read", cap_state, 4);
      again = 1; pkt_done = 1; skip_cnt = 0;
      cyc(); again = 0; pkt_done = 0; mode = 1;
      #1;
      chk("t7_state", cap_state, 2);
      chk("t7_grant", pkt_rd_grant, 0);

      // T6: asynchronous reset while filling at address 5
      repeat (5) cyc();
      #1;
      chk("t6_addr5", mem_wr_addr, 5);
      cyc(); mdio_addr = 0; rstn = 1'b0;
      #1;
      chk("t6_state", cap_state, 0);
      chk("t6_wr_en", mem_wr_en, 0);
      chk("t6_wr_addr", mem_wr_addr, 0);
      chk("t6_busy", cap_busy, 0);
      chk("t6_done", cap_done, 0);
      chk("t6_grant", pkt_rd_grant, 0);
      chk("t6_rd_addr", mem_rd_addr, 0);
      chk("t6_frames", cap_frame_cnt, 0);
      cyc(); wr_log.delete();
      cyc(); rstn = 1'b1;
      repeat (4) cyc();
      #1;
      chk("t6_no_wr", wr_log.size(), 0);
      chk("t6_idle", cap_state, 0);
      start = 1;
      cyc(); start = 0;
      cyc();
      #1;
      chk("t6_restart", cap_state, 2);
      chk("t6_addr1", mem_wr_addr, 1);

      cyc();
      valid = 0;
      cyc();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
